spart_bus_arbiter: RTL and testbench
====================================

Name: spart_bus_arbiter

Overview:
- Shares the single SPART processor-side bus (iocs/iorw/ioaddr/databus) among NUM_REQ independent requesters, for example a baud-config sequencer, a TX producer and an RX consumer.
- Performs one complete bus transaction per grant and gates data-register accesses on tbr/rda.
- Returns read data with a done pulse.
- Sits between the client logic and the SPART, replacing direct per-client bus driving.

Parameters:
- NUM_REQ, 2: number of requesters; legal values 2..4.
- WAIT_LIMIT, 255: cycles to wait for tbr/rda before timeout. Used only with SPART_ARB_TIMEOUT_EN. 8-bit counter.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until its done pulse.
- req_rw  in  NUM_REQ  1=read, 0=write, per requester.
- req_addr  in  2*NUM_REQ  SPART register address, slice k = [2k+1:2k].
- req_wdata  in  8*NUM_REQ  write data, slice k = [8k+7:8k].
- gnt  out  NUM_REQ  one-hot owner of the current transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  8  read data, valid in the done cycle; held until the next read completes.
- err  out  1  timeout flag, valid with done. Constant 0 when the optional feature is compiled out.
- iocs  out  1  SPART chip select.
- iorw  out  1  SPART direction, 1=read.
- ioaddr  out  2  SPART register address: 00 data, 01 status, 10 DB-low, 11 DB-high.
- databus  inout  8  driven with the latched wdata only when iocs=1 and iorw=0; high-Z otherwise.
- rda  in  1  SPART receive data available.
- tbr  in  1  SPART transmit buffer ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: iocs=0, iorw=1, ioaddr=00, databus=Z, gnt=0, done=0, rdata=00, err=0.
  - State=IDLE; round-robin pointer set so requester 0 wins first.
  - Reset mid-transaction aborts it immediately. No done is issued; requesters re-request.
- All outputs are registered. The FSM is IDLE, WAIT_RDY, ISSUE, CAPTURE, RESP.
- IDLE:
  - If any req is high, choose a winner by round-robin, searching from last winner+1 upward with wrap.
  - Latch the winner's rw/addr/wdata, assert gnt[winner], go to WAIT_RDY.
  - If no req, stay in IDLE with iocs=0.
- WAIT_RDY:
  - Stay while (addr=00 & write & tbr=0) or (addr=00 & read & rda=0).
  - Addresses 01/10/11 never wait.
  - Otherwise go to ISSUE next cycle.
- ISSUE (1 cycle):
  - iocs=1, iorw=rw, ioaddr=addr.
  - On a write, databus is driven with wdata during this cycle only.
  - Write goes to RESP; read goes to CAPTURE.
- CAPTURE (1 cycle):
  - iocs=1, iorw=1, ioaddr held.
  - Sample databus into rdata at the end of the cycle, then go to RESP.
- RESP (1 cycle):
  - iocs=0, iorw=1, done[owner]=1.
  - Record the owner as last winner; clear gnt at the end of the cycle; go to IDLE.
- Latency with no wait: write grant to done is 3 cycles (WAIT_RDY, ISSUE, RESP); read is 4 cycles.
- Only one transaction is ever in flight; gnt is exactly one-hot or all-zero.
- Requester k must drop req in the cycle after done[k]. If req is still high in IDLE, it is a new transaction subject to round-robin.
- Changes to req/rw/addr/wdata after grant are ignored; values are latched in IDLE.
- A requester deasserting req while granted does not cancel the transaction, and done is still pulsed.
- Simultaneous requests: the lowest index at or after pointer+1 wins. Each active requester is guaranteed service within NUM_REQ transactions.

Optional Feature:
- Macro SPART_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in WAIT_RDY.
  - When it reaches WAIT_LIMIT, skip ISSUE and go to RESP with err=1 and rdata unchanged.
  - The counter clears on entering WAIT_RDY.
- Undefined:
  - WAIT_RDY waits indefinitely; err is tied to 0; no counter logic.

Test Plan:
- Req0 write addr=10 wdata=8'h16 with tbr=0 -> no wait; iocs=1, iorw=0, ioaddr=10, databus=16 for 1 cycle; done[0] 3 cycles after gnt.
- Req1 read addr=00, rda=0 for 10 cycles then 1, SPART drives 8'h5A -> ISSUE starts the cycle after rda rises; rdata=5A with done[1].
- req0 and req1 both held high for 4 transactions from reset -> grant order 0,1,0,1; gnt never multi-hot.
- Write addr=00 with tbr=0 for 300 cycles, SPART_ARB_TIMEOUT_EN defined, WAIT_LIMIT=255 -> done with err=1, iocs never asserted. Without the macro -> still waiting, err=0.
- rst=0 asserted during CAPTURE -> same-cycle iocs=0, databus=Z, gnt=0, no done; after release req0 wins first.

Source files
------------

// File: rtl/spart_bus_arbiter.sv
// spart_bus_arbiter: round-robin owner of the SPART processor bus; one full transaction per grant.
// Define SPART_ARB_TIMEOUT_EN to abort a ready-wait after WAIT_LIMIT cycles with err=1.
`timescale 1ns/1ps
module spart_bus_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WAIT_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [2*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 iocs,
  output logic                 iorw,
  output logic [1:0]           ioaddr,
  inout  wire  [7:0]           databus,
  input  logic                 rda,
  input  logic                 tbr
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_param
    $error("spart_bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t             r_state;
  logic [1:0]         r_last;
  logic [1:0]         r_owner;
  logic               r_rw;
  logic [1:0]         r_addr;
  logic [7:0]         r_wdata;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic [7:0]         r_rdata;
  logic               r_iocs;
  logic               r_iorw;
  logic [1:0]         r_ioaddr;

  logic               w_any;
  logic               w_rdy;
  logic [1:0]         w_win;
  logic [3:0]         w_req4;
  logic [3:0]         w_rw4;
  logic [7:0]         w_addr8;
  logic [31:0]        w_wdata32;

  // Requester vectors widened to the 4-requester maximum so a 2-bit index always fits.
  assign w_req4    = 4'(req);
  assign w_rw4     = 4'(req_rw);
  assign w_addr8   = 8'(req_addr);
  assign w_wdata32 = 32'(req_wdata);

  function automatic logic [1:0] next_idx(input logic [1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return sum[1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v[NUM_REQ-1:0];
  endfunction

  // Scan farthest-first so the requester closest after the last winner overrides the rest.
  always_comb begin
    w_any = |req;
    w_win = r_last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (w_req4[next_idx(r_last, i)]) w_win = next_idx(r_last, i);
    end
  end

  assign w_rdy = (r_addr != 2'b00) || (r_rw ? rda : tbr);

`ifdef SPART_ARB_TIMEOUT_EN
  localparam logic [7:0] WAIT_CNT = 8'(WAIT_LIMIT);
  logic       r_err;
  logic [7:0] r_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_last   <= 2'(NUM_REQ - 1);
      r_owner  <= 2'b00;
      r_rw     <= 1'b1;
      r_addr   <= 2'b00;
      r_wdata  <= 8'h00;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= 8'h00;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= 2'b00;
`ifdef SPART_ARB_TIMEOUT_EN
      r_err    <= 1'b0;
      r_cnt    <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_win;
            r_rw    <= w_rw4[w_win];
            r_addr  <= w_addr8[{w_win, 1'b0} +: 2];
            r_wdata <= w_wdata32[{w_win, 3'b000} +: 8];
            r_gnt   <= onehot(w_win);
            r_state <= S_WAIT_RDY;
`ifdef SPART_ARB_TIMEOUT_EN
            r_cnt   <= 8'h00;
`endif
          end
        end
        S_WAIT_RDY: begin
          if (w_rdy) begin
            r_iocs   <= 1'b1;
            r_iorw   <= r_rw;
            r_ioaddr <= r_addr;
            r_state  <= S_ISSUE;
          end
`ifdef SPART_ARB_TIMEOUT_EN
          else if (r_cnt == WAIT_CNT) begin
            r_done  <= onehot(r_owner);
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        S_ISSUE: begin
          if (r_rw) begin
            r_state <= S_CAPTURE;
          end else begin
            r_iocs  <= 1'b0;
            r_iorw  <= 1'b1;
            r_done  <= onehot(r_owner);
            r_state <= S_RESP;
          end
        end
        S_CAPTURE: begin
          r_rdata <= databus;
          r_iocs  <= 1'b0;
          r_iorw  <= 1'b1;
          r_done  <= onehot(r_owner);
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_last  <= r_owner;
          r_state <= S_IDLE;
`ifdef SPART_ARB_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign iocs    = r_iocs;
  assign iorw    = r_iorw;
  assign ioaddr  = r_ioaddr;
  assign databus = (r_iocs && !r_iorw) ? r_wdata : 8'hzz;

`ifdef SPART_ARB_TIMEOUT_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Directed bench for spart_bus_arbiter: vector table of single transactions plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_spart_bus_arbiter;
  localparam int NUM_REQ = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [2*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rdata;
  logic                 err;
  logic                 iocs;
  logic                 iorw;
  logic [1:0]           ioaddr;
  wire  [7:0]           databus;
  logic                 rda;
  logic                 tbr;
  logic [7:0]           spart_val;
  logic                 probe_en;

  int checks = 0;
  int errors = 0;

  // SPART side: answers reads; the probe value exposes any DUT drive while the bus should float.
  assign databus = (iocs && iorw) ? spart_val : (probe_en ? 8'h81 : 8'hzz);

  always #5 clk = ~clk;

  spart_bus_arbiter #(.NUM_REQ(NUM_REQ), .WAIT_LIMIT(255)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr)
  );

  typedef struct {
    int         k;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] bus;
    logic       tbr;
    logic       rda;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_float(input string name);
    probe_en = 1'b1;
    #1;
    chk(name, databus, 8'h81);
    probe_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    logic [1:0] oh;
    oh = 2'b01 << v.k;
    tbr = v.tbr;
    rda = v.rda;
    spart_val = v.bus;
    req = oh;
    req_rw[v.k] = v.rw;
    req_addr[2*v.k +: 2] = v.addr;
    req_wdata[8*v.k +: 8] = v.wdata;
    step();
    chk($sformatf("vec%0d gnt", n), gnt, oh);
    chk($sformatf("vec%0d wait iocs", n), iocs, 0);
    // Post-grant changes must not leak into the transaction.
    req = '0;
    req_rw[v.k] = ~v.rw;
    req_addr[2*v.k +: 2] = ~v.addr;
    req_wdata[8*v.k +: 8] = ~v.wdata;
    step();
    chk($sformatf("vec%0d issue iocs", n), iocs, 1);
    chk($sformatf("vec%0d issue iorw", n), iorw, v.rw);
    chk($sformatf("vec%0d issue ioaddr", n), ioaddr, v.addr);
    chk($sformatf("vec%0d issue done", n), done, 0);
    if (!v.rw) chk($sformatf("vec%0d databus", n), databus, v.wdata);
    if (v.rw) begin
      step();
      chk($sformatf("vec%0d capture iocs", n), iocs, 1);
      chk($sformatf("vec%0d capture iorw", n), iorw, 1);
      chk($sformatf("vec%0d capture done", n), done, 0);
    end
    step();
    chk($sformatf("vec%0d done", n), done, oh);
    chk($sformatf("vec%0d resp iocs", n), iocs, 0);
    chk($sformatf("vec%0d resp gnt", n), gnt, oh);
    chk($sformatf("vec%0d rdata", n), rdata, v.exp_rdata);
    chk($sformatf("vec%0d err", n), err, 0);
    step();
    chk($sformatf("vec%0d idle gnt", n), gnt, 0);
    chk($sformatf("vec%0d idle done", n), done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    int n_done;
    int exp_order[4];
    logic seen_iocs;
    logic got_done;
    logic got_err;

    vecs[0] = '{k: 0, rw: 1'b0, addr: 2'b10, wdata: 8'h16, bus: 8'h00, tbr: 1'b0, rda: 1'b0, exp_rdata: 8'h00};
    vecs[1] = '{k: 1, rw: 1'b1, addr: 2'b01, wdata: 8'h00, bus: 8'hA5, tbr: 1'b0, rda: 1'b0, exp_rdata: 8'hA5};
    vecs[2] = '{k: 0, rw: 1'b0, addr: 2'b11, wdata: 8'hC3, bus: 8'h00, tbr: 1'b0, rda: 1'b0, exp_rdata: 8'hA5};
    vecs[3] = '{k: 1, rw: 1'b1, addr: 2'b00, wdata: 8'h00, bus: 8'h3C, tbr: 1'b0, rda: 1'b1, exp_rdata: 8'h3C};
    vecs[4] = '{k: 0, rw: 1'b0, addr: 2'b00, wdata: 8'h7E, bus: 8'h00, tbr: 1'b1, rda: 1'b0, exp_rdata: 8'h3C};
    vecs[5] = '{k: 1, rw: 1'b1, addr: 2'b10, wdata: 8'h00, bus: 8'hFF, tbr: 1'b0, rda: 1'b0, exp_rdata: 8'hFF};
    exp_order = '{1, 2, 1, 2};

    rst = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    rda = 1'b0; tbr = 1'b0; spart_val = 8'h00; probe_en = 1'b0;
    step();
    step();
    chk("reset iocs", iocs, 0);
    chk("reset iorw", iorw, 1);
    chk("reset ioaddr", ioaddr, 0);
    chk("reset gnt", gnt, 0);
    chk("reset done", done, 0);
    chk("reset rdata", rdata, 0);
    chk("reset err", err, 0);
    check_float("reset databus float");
    rst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Read of the data register stalls until rda rises.
    req = 2'b10; req_rw = 2'b10; req_addr = 4'b0000; rda = 1'b0; tbr = 1'b0; spart_val = 8'h5A;
    step();
    chk("rdwait gnt", gnt, 2'b10);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("rdwait hold iocs c%0d", c), iocs, 0);
    end
    rda = 1'b1;
    step();
    chk("rdwait issue iocs", iocs, 1);
    chk("rdwait issue iorw", iorw, 1);
    step();
    chk("rdwait capture iocs", iocs, 1);
    step();
    chk("rdwait done", done, 2'b10);
    chk("rdwait rdata", rdata, 8'h5A);
    req = '0; rda = 1'b0;
    step();

    // Two persistent requesters alternate from reset.
    do_reset();
    req_rw = 2'b00; req_addr = 4'b0101; req_wdata = 16'h2211; tbr = 1'b1; req = 2'b11;
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 4; c++) begin
      step();
      chk("rr gnt onehot0", 32'($onehot0(gnt)), 1);
      if (done != 0) begin
        chk($sformatf("rr order %0d", n_done), done, exp_order[n_done]);
        n_done++;
      end
    end
    chk("rr done count", n_done, 4);
    req = '0;
    step();

    // Write to data register with tbr stuck low.
    req = 2'b01; req_rw = 2'b00; req_addr = 4'b0000; req_wdata = 16'h0044; tbr = 1'b0;
    seen_iocs = 1'b0; got_done = 1'b0; got_err = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (iocs) seen_iocs = 1'b1;
      if (done != 0 && !got_done) begin
        got_done = 1'b1;
        got_err = err;
        req = '0;
      end
    end
`ifdef SPART_ARB_TIMEOUT_EN
    chk("timeout done", got_done, 1);
    chk("timeout err", got_err, 1);
    chk("timeout iocs", seen_iocs, 0);
`else
    chk("stall no done", got_done, 0);
    chk("stall iocs", seen_iocs, 0);
    chk("stall err", err, 0);
    tbr = 1'b1;
    step();
    chk("stall release iocs", iocs, 1);
    chk("stall release databus", databus, 8'h44);
    step();
    chk("stall release done", done, 2'b01);
    chk("stall release err", err, 0);
    req = '0;
`endif
    step();

    // Asynchronous reset in the middle of a read.
    req = 2'b10; req_rw = 2'b10; req_addr = 4'b0100; spart_val = 8'h99; tbr = 1'b1; rda = 1'b1;
    step();
    chk("abort gnt", gnt, 2'b10);
    step();
    step();
    chk("abort capture iocs", iocs, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort iocs", iocs, 0);
    chk("abort gnt cleared", gnt, 0);
    chk("abort done", done, 0);
    check_float("abort databus float");
    step();
    chk("abort held done", done, 0);
    rst = 1'b1;
    req = 2'b11; req_rw = 2'b10; req_addr = 4'b0100; req_wdata = 16'h0055;
    step();
    chk("post-reset winner", gnt, 2'b01);
    req = 2'b10;
    step();
    chk("post-reset issue iocs", iocs, 1);
    step();
    chk("post-reset done", done, 2'b01);
    req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
